// File: rtl/draw_rect.sv
// draw_rect: overlays a solid rectangle with an optional border on the pixel stream, at a position latched once per frame.
// Latency: exactly 2 pclk cycles from every *_in to the matching *_out; one pixel accepted and produced every cycle.
// Backpressure: none; the stream is free-running, and the timing strobes travel through the same 2 stages as the colour.
//
// Ports:
//   pclk, reset                           pixel clock; asynchronous active-high reset
//   hcount_in, vcount_in, *sync/*blnk_in  timing from the VGA timing generator
//   rgb_in                                background colour, aligned with hcount_in
//   xpos, ypos                            requested top-left corner, sampled only at the vblnk_in rising edge
//   hcount_out .. vblnk_out, rgb_out      timing delayed by 2 cycles, plus the composited colour
module draw_rect #(
  parameter int          RECT_W       = 48,
  parameter int          RECT_H       = 64,
  parameter int          BORDER       = 2,
  parameter logic [11:0] FILL_COLOR   = 12'hF00,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF,
  parameter int          H_ACTIVE     = 800,
  parameter int          V_ACTIVE     = 600
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
  } timing_t;

  // Largest corner that still keeps the whole rectangle on screen.
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - RECT_W);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - RECT_H);
  localparam logic [12:0] W13   = 13'(RECT_W);
  localparam logic [12:0] H13   = 13'(RECT_H);
  localparam logic [12:0] B13   = 13'(BORDER);

  // ---------------------------------------------------------------------------
  // Position latch: geometry only moves at the start of vertical blank.
  // ---------------------------------------------------------------------------
  logic        vblnk_d;
  logic [11:0] x_l;
  logic [11:0] y_l;
  logic        frame_start;

  assign frame_start = vblnk_in & ~vblnk_d;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vblnk_d <= 1'b0;
      x_l     <= 12'd0;
      y_l     <= 12'd0;
    end else begin
      vblnk_d <= vblnk_in;
      if (frame_start) begin
        x_l <= (xpos > X_MAX) ? X_MAX : xpos;
        y_l <= (ypos > Y_MAX) ? Y_MAX : ypos;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Geometry compare, evaluated at 13 bits so nothing can wrap.
  // ---------------------------------------------------------------------------
  logic [12:0] h13, v13;
  logic [12:0] x0, x1, y0, y1;
  logic [12:0] hb13, vb13;
  logic        inside_c;
  logic        border_c;

  assign h13  = {1'b0, hcount_in};
  assign v13  = {1'b0, vcount_in};
  assign x0   = {1'b0, x_l};
  assign y0   = {1'b0, y_l};
  assign x1   = x0 + W13;
  assign y1   = y0 + H13;
  // "count >= start+SIZE-BORDER" is tested as "count+BORDER >= start+SIZE"
  // so an oversized border cannot underflow the right-hand side.
  assign hb13 = h13 + B13;
  assign vb13 = v13 + B13;

  assign inside_c = (h13 >= x0) && (h13 < x1) && (v13 >= y0) && (v13 < y1);
  assign border_c = inside_c &&
                    ((h13 < x0 + B13) || (hb13 >= x1) ||
                     (v13 < y0 + B13) || (vb13 >= y1));

  // ---------------------------------------------------------------------------
  // Stage 1: register timing, background and the compare results.
  // ---------------------------------------------------------------------------
  timing_t     t_in;
  timing_t     s1_t;
  logic [11:0] s1_rgb;
  logic        s1_inside;
  logic        s1_border;

  assign t_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      s1_t      <= '0;
      s1_rgb    <= 12'h000;
      s1_inside <= 1'b0;
      s1_border <= 1'b0;
    end else begin
      s1_t      <= t_in;
      s1_rgb    <= rgb_in;
      s1_inside <= inside_c;
      s1_border <= border_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour select (blank > border > fill > background).
  // ---------------------------------------------------------------------------
  logic [11:0] rgb_nxt;
  timing_t     s2_t;
  logic [11:0] s2_rgb;

  always_comb begin
    rgb_nxt = s1_rgb;
    if (s1_t.hblnk || s1_t.vblnk) begin
      rgb_nxt = 12'h000;
    end else if (s1_border) begin
      rgb_nxt = BORDER_COLOR;
    end else if (s1_inside) begin
      rgb_nxt = FILL_COLOR;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      s2_t   <= '0;
      s2_rgb <= 12'h000;
    end else begin
      s2_t   <= s1_t;
      s2_rgb <= rgb_nxt;
    end
  end

  assign hcount_out = s2_t.hcount;
  assign vcount_out = s2_t.vcount;
  assign hsync_out  = s2_t.hsync;
  assign hblnk_out  = s2_t.hblnk;
  assign vsync_out  = s2_t.vsync;
  assign vblnk_out  = s2_t.vblnk;
  assign rgb_out    = s2_rgb;

endmodule

// File: tb/tb_draw_rect.sv
// tb_draw_rect: drives draw_rect (default build and a BORDER=0 build side by side) with table vectors,
// hand-written corner sequences and random pixels, checking every output cycle against a
// pixel-geometry reference model and fixed expected colours.
module tb_draw_rect;

  localparam int          RW   = 48;
  localparam int          RH   = 64;
  localparam int          BW   = 2;
  localparam logic [11:0] FCOL = 12'hF00;
  localparam logic [11:0] BCOL = 12'hFFF;
  localparam int          XMAX = 800 - RW;
  localparam int          YMAX = 600 - RH;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0, xpos = '0, ypos = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;

  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] nb_hcount_out, nb_vcount_out, nb_rgb_out;
  logic        nb_hsync_out, nb_hblnk_out, nb_vsync_out, nb_vblnk_out;

  always #5 pclk = ~pclk;

  draw_rect dut (
    .pclk(pclk), .reset(reset),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  draw_rect #(.BORDER(0)) dut_nb (
    .pclk(pclk), .reset(reset),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .hcount_out(nb_hcount_out), .vcount_out(nb_vcount_out),
    .hsync_out(nb_hsync_out), .hblnk_out(nb_hblnk_out), .vsync_out(nb_vsync_out),
    .vblnk_out(nb_vblnk_out), .rgb_out(nb_rgb_out)
  );

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
    logic [11:0] rgb_nb;
  } out_t;

  typedef struct {
    logic [11:0] xp, yp, bg, h, v, exp, exp_nb;
  } vec_t;

  int   nerr = 0;
  int   nchk = 0;
  out_t q[$];
  int   xl_m = 0;
  int   yl_m = 0;
  logic vbd_m = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Colour of one pixel from the rectangle's geometry: distance to the nearest edge decides border.
  function automatic logic [11:0] ref_rgb(input int h, input int v, input logic blank,
                                          input logic [11:0] bg, input int xl, input int yl,
                                          input int b);
    int dx, dy, e;
    if (blank) return 12'h000;
    dx = h - xl;
    dy = v - yl;
    if (dx < 0 || dx >= RW || dy < 0 || dy >= RH) return bg;
    e = dx;
    if (RW - 1 - dx < e) e = RW - 1 - dx;
    if (dy < e) e = dy;
    if (RH - 1 - dy < e) e = RH - 1 - dy;
    return (e < b) ? BCOL : FCOL;
  endfunction

  // One pixel cycle: drive at the falling edge, model it, then check the output that is now due.
  task automatic step(input logic [11:0] h, input logic [11:0] v, input logic hs, input logic hb,
                      input logic vs, input logic vb, input bit do_rst = 1'b0);
    out_t e, a;
    hcount_in = h; vcount_in = v;
    hsync_in = hs; hblnk_in = hb; vsync_in = vs; vblnk_in = vb;
    if (do_rst) begin
      #2 reset = 1'b1;
      #1 chk("async_reset_outputs_zero",
             {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out, nb_rgb_out},
             64'd0);
      #1 reset = 1'b0;
      q.delete();
      xl_m = 0; yl_m = 0; vbd_m = 1'b0;
    end
    e.h = h; e.v = v; e.hs = hs; e.hb = hb; e.vs = vs; e.vb = vb;
    e.rgb    = ref_rgb(int'(h), int'(v), hb | vb, rgb_in, xl_m, yl_m, BW);
    e.rgb_nb = ref_rgb(int'(h), int'(v), hb | vb, rgb_in, xl_m, yl_m, 0);
    q.push_back(e);
    @(posedge pclk);
    if (vb && !vbd_m) begin
      xl_m = (int'(xpos) > XMAX) ? XMAX : int'(xpos);
      yl_m = (int'(ypos) > YMAX) ? YMAX : int'(ypos);
    end
    vbd_m = vb;
    @(negedge pclk);
    if (q.size() == 2) begin
      e = q.pop_front();
      a = {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out, nb_rgb_out};
      chk("pipe_output", a, e);
      chk("pipe_nb_timing",
          {nb_hcount_out, nb_vcount_out, nb_hsync_out, nb_hblnk_out, nb_vsync_out, nb_vblnk_out},
          {e.h, e.v, e.hs, e.hb, e.vs, e.vb});
      if (hblnk_out || vblnk_out) chk("blank_is_black", rgb_out, 12'h000);
    end
  endtask

  task automatic vpulse();
    step(12'd0, 12'd600, 1'b0, 1'b1, 1'b0, 1'b1);
    step(12'd0, 12'd601, 1'b0, 1'b1, 1'b1, 1'b1);
    step(12'd0, 12'd602, 1'b0, 1'b1, 1'b1, 1'b1);
    step(12'd0, 12'd603, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  // Pixel (h,v) followed by one blank cycle; afterwards rgb_out shows that pixel.
  task automatic probe(input logic [11:0] h, input logic [11:0] v);
    step(h, v, 1'b0, 1'b0, 1'b0, 1'b0);
    step(12'd840, v, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic probe_chk(input string name, input logic [11:0] h, input logic [11:0] v,
                           input logic [11:0] exp, input logic [11:0] exp_nb);
    probe(h, v);
    chk({name, "_rgb"}, rgb_out, exp);
    chk({name, "_rgb_nb"}, nb_rgb_out, exp_nb);
  endtask

  // Partial frame: vblank pulse, then lines y0..y1 over columns x0..x1 with a short hblank.
  task automatic scan(input int x0, input int x1, input int y0, input int y1,
                      input int chg, input logic [11:0] nx);
    vpulse();
    for (int v = y0; v <= y1; v++) begin
      if (v == chg) xpos = nx;
      for (int h = x0; h <= x1; h++) step(12'(h), 12'(v), 1'b0, 1'b0, 1'b0, 1'b0);
      step(12'd840, 12'(v), 1'b1, 1'b1, 1'b0, 1'b0);
      step(12'd841, 12'(v), 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [11:0] pick_pos();
    case ($urandom_range(0, 3))
      0:       return 12'($urandom_range(0, 4095));
      1:       return 12'($urandom_range(700, 800));
      2:       return 12'd0;
      default: return 12'($urandom_range(0, 900));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[22];
    logic vb_s;
    logic [11:0] rh, rv;

    tbl[0]  = '{12'd100, 12'd200, 12'h00F, 12'd100, 12'd200, 12'hFFF, 12'hF00};
    tbl[1]  = '{12'd100, 12'd200, 12'h00F, 12'd102, 12'd202, 12'hF00, 12'hF00};
    tbl[2]  = '{12'd100, 12'd200, 12'h00F, 12'd99,  12'd200, 12'h00F, 12'h00F};
    tbl[3]  = '{12'd100, 12'd200, 12'h00F, 12'd147, 12'd263, 12'hFFF, 12'hF00};
    tbl[4]  = '{12'd100, 12'd200, 12'h00F, 12'd148, 12'd263, 12'h00F, 12'h00F};
    tbl[5]  = '{12'd100, 12'd200, 12'h00F, 12'd101, 12'd201, 12'hFFF, 12'hF00};
    tbl[6]  = '{12'd100, 12'd200, 12'h00F, 12'd145, 12'd261, 12'hF00, 12'hF00};
    tbl[7]  = '{12'd100, 12'd200, 12'h00F, 12'd146, 12'd262, 12'hFFF, 12'hF00};
    tbl[8]  = '{12'd100, 12'd200, 12'h00F, 12'd100, 12'd199, 12'h00F, 12'h00F};
    tbl[9]  = '{12'd100, 12'd200, 12'h00F, 12'd147, 12'd264, 12'h00F, 12'h00F};
    tbl[10] = '{12'hFFF, 12'd700, 12'h0A5, 12'd752, 12'd536, 12'hFFF, 12'hF00};
    tbl[11] = '{12'hFFF, 12'd700, 12'h0A5, 12'd751, 12'd536, 12'h0A5, 12'h0A5};
    tbl[12] = '{12'hFFF, 12'd700, 12'h0A5, 12'd754, 12'd538, 12'hF00, 12'hF00};
    tbl[13] = '{12'hFFF, 12'd700, 12'h0A5, 12'd799, 12'd599, 12'hFFF, 12'hF00};
    tbl[14] = '{12'hFFF, 12'd700, 12'h0A5, 12'd0,   12'd536, 12'h0A5, 12'h0A5};
    tbl[15] = '{12'hFFF, 12'd700, 12'h0A5, 12'd775, 12'd535, 12'h0A5, 12'h0A5};
    tbl[16] = '{12'hFFF, 12'd700, 12'h0A5, 12'd3,   12'd599, 12'h0A5, 12'h0A5};
    tbl[17] = '{12'd0,   12'd0,   12'h0A5, 12'd0,   12'd0,   12'hFFF, 12'hF00};
    tbl[18] = '{12'd0,   12'd0,   12'h0A5, 12'd2,   12'd2,   12'hF00, 12'hF00};
    tbl[19] = '{12'd0,   12'd0,   12'h0A5, 12'd47,  12'd63,  12'hFFF, 12'hF00};
    tbl[20] = '{12'd0,   12'd0,   12'h0A5, 12'd48,  12'd2,   12'h0A5, 12'h0A5};
    tbl[21] = '{12'd752, 12'd537, 12'h0A5, 12'd752, 12'd536, 12'hFFF, 12'hF00};

    // Reset with busy inputs; vblnk_in stays high across release.
    hcount_in = 12'd123; vcount_in = 12'd601; rgb_in = 12'hABC;
    hsync_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b1; vblnk_in = 1'b1;
    xpos = 12'd100; ypos = 12'd200;
    repeat (3) @(negedge pclk);
    chk("reset_hcount_out", hcount_out, 12'd0);
    chk("reset_vcount_out", vcount_out, 12'd0);
    chk("reset_strobes", {hsync_out, hblnk_out, vsync_out, vblnk_out}, 4'b0000);
    chk("reset_rgb_out", rgb_out, 12'h000);
    chk("reset_rgb_out_nb", nb_rgb_out, 12'h000);
    reset = 1'b0;

    // Full region scan at (100,200); the first cycle latches because vblnk_in was already high.
    rgb_in = 12'h00F;
    scan(97, 151, 198, 265, 4095, 12'd0);

    for (int i = 0; i < 22; i++) begin
      xpos = tbl[i].xp; ypos = tbl[i].yp; rgb_in = tbl[i].bg;
      vpulse();
      probe(tbl[i].h, tbl[i].v);
      chk($sformatf("tbl%0d_rgb", i), rgb_out, tbl[i].exp);
      chk($sformatf("tbl%0d_rgb_nb", i), nb_rgb_out, tbl[i].exp_nb);
      chk($sformatf("tbl%0d_hcount", i), hcount_out, tbl[i].h);
    end

    // Mid-frame position change: this frame stays at x=100, the next moves to x=300.
    rgb_in = 12'h123; xpos = 12'd100; ypos = 12'd40;
    scan(95, 355, 45, 60, 50, 12'd300);
    probe_chk("midframe_old_pos", 12'd110, 12'd55, 12'hF00, 12'hF00);
    probe_chk("midframe_new_pos_not_yet", 12'd310, 12'd55, 12'h123, 12'h123);
    scan(95, 355, 45, 60, 4095, 12'd0);
    probe_chk("nextframe_new_pos", 12'd310, 12'd55, 12'hF00, 12'hF00);
    probe_chk("nextframe_old_pos_gone", 12'd110, 12'd55, 12'h123, 12'h123);

    // Clamped corner: right/bottom edges and no wrap to column 0.
    rgb_in = 12'h0A5; xpos = 12'hFFF; ypos = 12'd700;
    scan(745, 799, 533, 599, 4095, 12'd0);
    scan(0, 5, 533, 599, 4095, 12'd0);

    // Sub-cycle reset pulse mid-frame; position falls back to (0,0) until the next vblank rise.
    xpos = 12'd555; ypos = 12'd300;
    step(12'd400, 12'd300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(12'd401, 12'd300, 1'b0, 1'b0, 1'b0, 1'b0);
    step(12'd840, 12'd300, 1'b1, 1'b1, 1'b0, 1'b0);
    probe_chk("after_reset_origin", 12'd0, 12'd0, 12'hFFF, 12'hF00);
    probe_chk("after_reset_fill", 12'd10, 12'd10, 12'hF00, 12'hF00);
    probe_chk("after_reset_right_bg", 12'd48, 12'd10, 12'h0A5, 12'h0A5);
    probe_chk("after_reset_below_bg", 12'd10, 12'd64, 12'h0A5, 12'h0A5);
    vpulse();
    probe_chk("after_reset_relatch_fill", 12'd565, 12'd310, 12'hF00, 12'hF00);
    probe_chk("after_reset_relatch_corner", 12'd555, 12'd300, 12'hFFF, 12'hF00);

    // Random pixels around the latched rectangle with randomly moving requests and blanks.
    vb_s = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(0, 7) == 0) xpos = pick_pos();
      if ($urandom_range(0, 7) == 0) ypos = pick_pos();
      if ($urandom_range(0, 31) == 0) rgb_in = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 39) == 0) vb_s = ~vb_s;
      rh = 12'(xl_m + int'($urandom_range(0, RW + 10)) - 5);
      rv = 12'(yl_m + int'($urandom_range(0, RH + 10)) - 5);
      if ($urandom_range(0, 9) == 0) rh = 12'($urandom_range(0, 4095));
      step(rh, rv, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), vb_s);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
